// File: rtl/poly_eval_pkg.sv
// Shared encodings for the Horner polynomial evaluator: FSM states, ALU ops,
// and the index-width helper used by both the top and the datapath.
package poly_eval_pkg;
  localparam logic [2:0] LOAD        = 3'd0;
  localparam logic [2:0] LOAD_WAIT   = 3'd1;
  localparam logic [2:0] LOAD_X      = 3'd2;
  localparam logic [2:0] LOAD_X_WAIT = 3'd3;
  localparam logic [2:0] INIT        = 3'd4;
  localparam logic [2:0] MUL         = 3'd5;
  localparam logic [2:0] ADD         = 3'd6;
  localparam logic [2:0] DONE        = 3'd7;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  // Coefficient index width; at least one bit even for a constant polynomial.
  function automatic int kw(input int deg);
    return (deg < 1) ? 1 : $clog2(deg + 1);
  endfunction
endpackage

// File: rtl/poly_eval_datapath.sv
// Coefficient file, x, accumulator and the shared multiply/add ALU with
// overflow detection; the result register only moves on i_ld_r.
module poly_eval_datapath
  import poly_eval_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEGREE = 2,
  parameter int KW     = kw(DEGREE)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ld_coef,
  input  logic             i_ld_x,
  input  logic             i_acc_init,
  input  logic             i_alu_en,
  input  logic             i_alu_op,
  input  logic             i_ld_r,
  input  logic             i_ovf_clr,
  input  logic [KW-1:0]    i_k,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_result,
  output logic             o_ovf
);
  logic [DEGREE:0][WIDTH-1:0] r_coef;
  logic [WIDTH-1:0]           r_x;
  logic [WIDTH-1:0]           r_acc;
  logic [WIDTH-1:0]           r_result;
  logic                       r_ovf;

  logic [WIDTH-1:0]   w_coef_k;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_alu;
  logic               w_alu_ovf;

  assign w_coef_k  = r_coef[i_k];
  assign w_prod    = {{WIDTH{1'b0}}, r_acc} * {{WIDTH{1'b0}}, r_x};
  assign w_sum     = {1'b0, r_acc} + {1'b0, w_coef_k};
  assign w_alu     = (i_alu_op == OP_MUL) ? w_prod[WIDTH-1:0] : w_sum[WIDTH-1:0];
  // Any bit beyond WIDTH (high product half or add carry) marks overflow.
  assign w_alu_ovf = (i_alu_op == OP_MUL) ? |w_prod[2*WIDTH-1:WIDTH] : w_sum[WIDTH];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_coef <= '0;
    end else if (i_ld_coef) begin
      for (int i = 0; i <= DEGREE; i++)
        if (i_k == KW'(i)) r_coef[i] <= i_din;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_x      <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (i_ld_x)          r_x   <= i_din;
      if (i_acc_init)      r_acc <= r_coef[DEGREE];
      else if (i_alu_en)   r_acc <= w_alu;
      if (i_ovf_clr)       r_ovf <= 1'b0;
      else if (i_alu_en && w_alu_ovf) r_ovf <= 1'b1;
      // A constant polynomial finishes straight out of INIT.
      if (i_ld_r)          r_result <= i_acc_init ? r_coef[DEGREE] : w_alu;
    end
  end

  assign o_result = r_result;
  assign o_ovf    = r_ovf;
endmodule

// File: rtl/poly_eval_horner.sv
// Horner polynomial evaluator top: operand-load FSM, coefficient index k,
// and the shared-ALU datapath.
module poly_eval_horner
  import poly_eval_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEGREE = 2
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Go,
  input  logic             KeepCoeff,
  input  logic [WIDTH-1:0] DataIn,
  output logic [WIDTH-1:0] DataResult,
  output logic             ResultValid,
  output logic             Overflow,
  output logic             Busy
);
  localparam int KW = kw(DEGREE);
  localparam logic [KW-1:0] K_TOP  = KW'(DEGREE);
  localparam logic [KW-1:0] K_INIT = (DEGREE == 0) ? '0 : KW'(DEGREE - 1);

  logic [2:0]    r_state, w_next;
  logic [KW-1:0] r_k;
  logic [KW-1:0] w_idx;
  logic          w_ld_coef, w_ld_x, w_acc_init, w_alu_en, w_alu_op, w_ld_r, w_ovf_clr;
  logic          w_k_zero;

  assign w_k_zero = (r_k == '0);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) r_state <= LOAD;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      LOAD:        if (Go)  w_next = LOAD_WAIT;
      LOAD_WAIT:   if (!Go) w_next = w_k_zero ? LOAD_X : LOAD;
      LOAD_X:      if (Go)  w_next = LOAD_X_WAIT;
      LOAD_X_WAIT: if (!Go) w_next = INIT;
      INIT:        w_next = (DEGREE == 0) ? DONE : MUL;
      MUL:         w_next = ADD;
      ADD:         w_next = w_k_zero ? DONE : MUL;
      DONE:        if (Go)  w_next = KeepCoeff ? LOAD_X_WAIT : LOAD_WAIT;
      default:     w_next = LOAD;
    endcase
  end

  always_comb begin
    w_ld_coef   = 1'b0;
    w_ld_x      = 1'b0;
    w_acc_init  = 1'b0;
    w_alu_en    = 1'b0;
    w_alu_op    = OP_ADD;
    w_ld_r      = 1'b0;
    w_ovf_clr   = 1'b0;
    Busy        = 1'b0;
    ResultValid = 1'b0;
    case (r_state)
      LOAD:   w_ld_coef = Go;
      LOAD_X: w_ld_x    = Go;
      INIT: begin
        Busy       = 1'b1;
        w_acc_init = 1'b1;
        w_ovf_clr  = 1'b1;
        w_ld_r     = (DEGREE == 0);
      end
      MUL: begin
        Busy     = 1'b1;
        w_alu_en = 1'b1;
        w_alu_op = OP_MUL;
      end
      ADD: begin
        Busy     = 1'b1;
        w_alu_en = 1'b1;
        w_ld_r   = w_k_zero;
      end
      DONE: begin
        ResultValid = 1'b1;
        w_ld_x      = Go && KeepCoeff;
        w_ld_coef   = Go && !KeepCoeff;
      end
      default: ;
    endcase
  end

  // A fresh coefficient load out of DONE always lands in the top slot.
  assign w_idx = (r_state == DONE) ? K_TOP : r_k;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_k <= K_TOP;
    end else begin
      case (r_state)
        LOAD_WAIT: if (!Go && !w_k_zero) r_k <= r_k - KW'(1);
        INIT:      r_k <= K_INIT;
        ADD:       if (!w_k_zero) r_k <= r_k - KW'(1);
        DONE:      if (Go && !KeepCoeff) r_k <= K_TOP;
        default: ;
      endcase
    end
  end

  poly_eval_datapath #(.WIDTH(WIDTH), .DEGREE(DEGREE), .KW(KW)) u_dp (
    .i_clk      (Clock),
    .i_rst      (Reset),
    .i_ld_coef  (w_ld_coef),
    .i_ld_x     (w_ld_x),
    .i_acc_init (w_acc_init),
    .i_alu_en   (w_alu_en),
    .i_alu_op   (w_alu_op),
    .i_ld_r     (w_ld_r),
    .i_ovf_clr  (w_ovf_clr),
    .i_k        (w_idx),
    .i_din      (DataIn),
    .o_result   (DataResult),
    .o_ovf      (Overflow)
  );
endmodule

// File: tb/tb_poly_eval_horner.sv
// Directed bench for poly_eval_horner: a DEGREE=2 and a DEGREE=0 instance
// driven with hand-computed vectors.
module tb_poly_eval_horner;
  logic       clk = 1'b0;
  logic       rst;
  logic       go2, keep2, go0, keep0;
  logic [7:0] din2, din0;
  logic [7:0] res2, res0;
  logic       rv2, ovf2, busy2, rv0, ovf0, busy0;

  int n_chk  = 0;
  int n_fail = 0;
  int edges, bcyc;

  always #5 clk = ~clk;

  poly_eval_horner #(.WIDTH(8), .DEGREE(2)) u_d2 (
    .Clock(clk), .Reset(rst), .Go(go2), .KeepCoeff(keep2), .DataIn(din2),
    .DataResult(res2), .ResultValid(rv2), .Overflow(ovf2), .Busy(busy2)
  );

  poly_eval_horner #(.WIDTH(8), .DEGREE(0)) u_d0 (
    .Clock(clk), .Reset(rst), .Go(go0), .KeepCoeff(keep0), .DataIn(din0),
    .DataResult(res0), .ResultValid(rv0), .Overflow(ovf0), .Busy(busy0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One Go press/release: high for exactly one rising edge.
  task automatic press(input bit sel, input logic [7:0] v, input logic kc);
    @(negedge clk);
    if (sel) begin din0 = v; keep0 = kc; go0 = 1'b1; end
    else     begin din2 = v; keep2 = kc; go2 = 1'b1; end
    @(negedge clk);
    go0 = 1'b0;
    go2 = 1'b0;
  endtask

  task automatic load2(input logic [7:0] c2, c1, c0, x);
    press(0, c2, 0);
    press(0, c1, 0);
    press(0, c0, 0);
    press(0, x, 0);
  endtask

  // Counts edges (starting with the one that samples Go released) until ResultValid.
  task automatic run(input bit sel, output int n_edges, output int n_busy);
    n_edges = 0;
    n_busy  = 0;
    do begin
      @(posedge clk); #1;
      n_edges++;
      if (sel ? busy0 : busy2) n_busy++;
    end while (!(sel ? rv0 : rv2) && n_edges < 40);
  endtask

  initial begin
    rst = 1'b1;
    go2 = 1'b0; keep2 = 1'b0; din2 = '0;
    go0 = 1'b0; keep0 = 1'b0; din0 = '0;
    #1;
    chk("rst_result", res2, 0);
    chk("rst_valid",  rv2,  0);
    chk("rst_ovf",    ovf2, 0);
    chk("rst_busy",   busy2, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 2x^2 + 3x + 4 at x=5
    load2(8'd2, 8'd3, 8'd4, 8'd5);
    run(0, edges, bcyc);
    chk("basic_latency", edges, 6);
    chk("basic_busy",    bcyc,  5);
    chk("basic_result",  res2,  69);
    chk("basic_valid",   rv2,   1);
    chk("basic_ovf",     ovf2,  0);

    // reuse coefficients at x=2
    press(0, 8'd2, 1);
    chk("reuse_valid_drop", rv2,  0);
    chk("reuse_hold",       res2, 69);
    run(0, edges, bcyc);
    chk("reuse_latency", edges, 6);
    chk("reuse_result",  res2,  18);

    // Go toggled while busy is ignored; a Go held into DONE is a coefficient
    press(0, 8'd5, 1);
    @(posedge clk); #1;
    chk("ign_busy_init", busy2, 1);
    @(negedge clk); go2 = 1'b1; din2 = 8'd77; keep2 = 1'b1;
    @(negedge clk); go2 = 1'b0;
    @(negedge clk); go2 = 1'b1;
    @(negedge clk); go2 = 1'b0;
    @(negedge clk); go2 = 1'b1; din2 = 8'd9; keep2 = 1'b0;
    @(negedge clk);
    chk("ign_result", res2, 69);
    chk("ign_valid",  rv2,  1);
    @(negedge clk); go2 = 1'b0;
    chk("held_go_valid_drop", rv2,  0);
    chk("held_go_hold",       res2, 69);
    press(0, 8'd0, 0);
    press(0, 8'd1, 0);
    press(0, 8'd3, 0);
    run(0, edges, bcyc);
    chk("held_go_result", res2, 82);

    // multiply overflow: 16x^2 at x=16
    load2(8'd16, 8'd0, 8'd0, 8'd16);
    run(0, edges, bcyc);
    chk("mul_ovf_result", res2, 0);
    chk("mul_ovf_flag",   ovf2, 1);

    // add carry: 200x^2 + 100x at x=1
    load2(8'd200, 8'd100, 8'd0, 8'd1);
    run(0, edges, bcyc);
    chk("add_ovf_result", res2, 44);
    chk("add_ovf_flag",   ovf2, 1);

    load2(8'd0, 8'd0, 8'd7, 8'd9);
    run(0, edges, bcyc);
    chk("ovf_clear_result", res2, 7);
    chk("ovf_clear_flag",   ovf2, 0);

    // reset during MUL acts without a clock edge
    press(0, 8'd3, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_busy", busy2, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_result", res2, 0);
    chk("mid_rst_valid",  rv2,  0);
    chk("mid_rst_ovf",    ovf2, 0);
    chk("mid_rst_busy",   busy2, 0);
    @(negedge clk); rst = 1'b0;
    load2(8'd1, 8'd1, 8'd1, 8'd3);
    run(0, edges, bcyc);
    chk("post_rst_result",  res2,  13);
    chk("post_rst_latency", edges, 6);

    // constant polynomial instance
    press(1, 8'd42, 0);
    press(1, 8'd200, 0);
    run(1, edges, bcyc);
    chk("d0_latency", edges, 2);
    chk("d0_busy",    bcyc,  1);
    chk("d0_result",  res0,  42);
    chk("d0_valid",   rv0,   1);
    chk("d0_ovf",     ovf0,  0);
    press(1, 8'd7, 1);
    run(1, edges, bcyc);
    chk("d0_reuse_result", res0, 42);
    press(1, 8'd5, 0);
    press(1, 8'd9, 0);
    run(1, edges, bcyc);
    chk("d0_reload_result",  res0,  5);
    chk("d0_reload_latency", edges, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
